// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind the UART receiver with valid/ready head, occupancy and overflow status; UART_RX_FIFO_OVF_CNT_EN adds a saturating dropped-byte counter
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_done_i,
  output logic [7:0]               m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     overflow_o,
  input  logic                     ovf_clr_i
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LEVEL);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic pop, push, drop;
  // status and head are pure functions of the registered pointers
  always_comb begin
    count_o = wr_ptr - rd_ptr;
    empty_o = wr_ptr == rd_ptr;
    full_o = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    almost_full_o = count_o >= AF_C;
    m_valid_o = !empty_o;
    m_data_o = empty_o ? 8'h00 : mem[rd_ptr[AW-1:0]];
    pop = m_valid_o && m_ready_i;
    push = rx_done_i && (!full_o || pop);
    drop = rx_done_i && full_o && !pop;
  end
  // storage array, deliberately left unreset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data_i;
  // pointers and sticky overflow; a drop beats a concurrent clear
  always_ff @(posedge clk)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow_o <= 1'b1;
      else if (ovf_clr_i) overflow_o <= 1'b0;
    end
`ifdef UART_RX_FIFO_OVF_CNT_EN
  // saturating drop counter; a drop in the clearing cycle restarts it at 1
  always_ff @(posedge clk)
    if (!resetn) ovf_cnt_o <= 8'h00;
    else if (drop) ovf_cnt_o <= ovf_clr_i ? 8'h01 : (ovf_cnt_o == 8'hFF ? 8'hFF : ovf_cnt_o + 8'h01);
    else if (ovf_clr_i) ovf_cnt_o <= 8'h00;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic rx_done_i = 1'b0;
  logic [7:0] m_data_o;
  logic m_valid_o;
  logic m_ready_i = 1'b0;
  logic [4:0] count_o;
  logic empty_o, full_o, almost_full_o, overflow_o;
  logic ovf_clr_i = 1'b0;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_o;
`endif
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  bit m_ovf;
  int m_cnt;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .resetn(resetn), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
`ifdef UART_RX_FIFO_OVF_CNT_EN
    , .ovf_cnt_o(ovf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count", 32'(count_o), q.size());
    check("valid", 32'(m_valid_o), q.size() > 0);
    check("data", 32'(m_data_o), q.size() > 0 ? 32'(q[0]) : 0);
    check("empty", 32'(empty_o), q.size() == 0);
    check("full", 32'(full_o), q.size() == DEPTH);
    check("afull", 32'(almost_full_o), q.size() >= AF);
    check("ovf", 32'(overflow_o), 32'(m_ovf));
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("ovfcnt", 32'(ovf_cnt_o), m_cnt);
`endif
  endtask

  task automatic step(input bit d, input logic [7:0] din, input bit r, input bit c);
    bit pop, fl, drop;
    rx_done_i = d; rx_data_i = din; m_ready_i = r; ovf_clr_i = c;
    @(posedge clk);
    if (!resetn) begin
      q.delete(); m_ovf = 0; m_cnt = 0;
    end else begin
      pop = q.size() > 0 && r;
      fl = q.size() == DEPTH;
      drop = d && fl && !pop;
      if (pop) void'(q.pop_front());
      if (d && !drop) q.push_back(din);
      if (drop) begin
        m_ovf = 1;
        m_cnt = c ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      end else if (c) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1, 8'h99, 1, 1);
    resetn = 1'b1;
    check("rst_valid", 32'(m_valid_o), 0);
    check("rst_data", 32'(m_data_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_afull", 32'(almost_full_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("rst_ovfcnt", 32'(ovf_cnt_o), 0);
`endif
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) step(1, base + 8'(i), 0, 0);
  endtask

  typedef struct {
    bit d; logic [7:0] din; bit r; bit c;
    int cnt; bit v; logic [7:0] dout; bit ovf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0};
    tbl[1] = '{1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0};
    tbl[2] = '{0, 8'h00, 0, 0, 1, 1, 8'hA5, 0};
    tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[4] = '{1, 8'h3C, 1, 0, 1, 1, 8'h3C, 0};
    tbl[5] = '{1, 8'h5A, 1, 0, 1, 1, 8'h5A, 0};
    tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[7] = '{0, 8'h77, 1, 0, 0, 0, 8'h00, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].d, tbl[i].din, tbl[i].r, tbl[i].c);
      check($sformatf("tbl%0d_count", i), 32'(count_o), tbl[i].cnt);
      check($sformatf("tbl%0d_valid", i), 32'(m_valid_o), 32'(tbl[i].v));
      check($sformatf("tbl%0d_data", i), 32'(m_data_o), 32'(tbl[i].dout));
      check($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].ovf));
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0, 0);
      check("fill_afull", 32'(almost_full_o), i + 1 >= 12);
      check("fill_full", 32'(full_o), i + 1 == 16);
    end
    step(1, 8'hFF, 0, 0);
    check("drop_ovf", 32'(overflow_o), 1);
    check("drop_count", 32'(count_o), 16);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("drop_ovfcnt", 32'(ovf_cnt_o), 1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(m_data_o), i);
      step(0, 8'h00, 1, 0);
    end
    check("drain_empty", 32'(empty_o), 1);
    step(0, 8'h00, 0, 1);
    check("clr_ovf", 32'(overflow_o), 0);
    do_reset();
    fill(8'h20);
    step(1, 8'hEE, 1, 0);
    check("fullpop_count", 32'(count_o), 16);
    check("fullpop_ovf", 32'(overflow_o), 0);
    check("fullpop_full", 32'(full_o), 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("fullpop_drain", 32'(m_data_o), i == 15 ? 32'hEE : 32'(8'h21 + 8'(i)));
      step(0, 8'h00, 1, 0);
    end
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(1, 8'h10 + 8'(k), 1, 0);
      check("stream_data", 32'(m_data_o), 32'(8'h10 + 8'(k)));
      check("stream_count", 32'(count_o), 1);
    end
`ifdef UART_RX_FIFO_OVF_CNT_EN
    do_reset();
    fill(8'h40);
    for (int i = 0; i < 300; i++) step(1, 8'(i), 0, 0);
    check("sat_ovfcnt", 32'(ovf_cnt_o), 32'hFF);
    step(1, 8'h55, 0, 1);
    check("clrdrop_ovf", 32'(overflow_o), 1);
    check("clrdrop_cnt", 32'(ovf_cnt_o), 1);
    step(0, 8'h00, 0, 1);
    check("clr_cnt", 32'(ovf_cnt_o), 0);
`endif
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 200) % 3;
      step($urandom_range(0, 1) == 1, 8'($urandom),
           phase == 0 ? $urandom_range(0, 7) == 0 : phase == 1 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) != 0,
           $urandom_range(0, 31) == 0);
    end
    do_reset();
    fill(8'h60);
    step(1, 8'h01, 0, 0);
    check("mid_pre_ovf", 32'(overflow_o), 1);
    do_reset();
    step(0, 8'h00, 1, 0);
    check("post_rst_valid", 32'(m_valid_o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle completion pulse and stores it in a power-of-two circular FIFO. It presents the oldest byte to the consumer over a valid/ready interface and reports occupancy and overflow status.

## Interface

Parameters:
- DEPTH, 16: number of byte entries; power of two, >= 2.
- AF_LEVEL, 12: almost-full threshold; 1 <= AF_LEVEL <= DEPTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- rx_data_i  input  8  received byte; sampled only when rx_done_i=1.
- rx_done_i  input  1  one-cycle pulse, byte available.
- m_data_o  output  8  head-of-FIFO byte.
- m_valid_o  output  1  FIFO non-empty.
- m_ready_i  input  1  consumer accepts head byte.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty_o  output  1  count_o==0.
- full_o  output  1  count_o==DEPTH.
- almost_full_o  output  1  count_o>=AF_LEVEL.
- overflow_o  output  1  sticky; a byte was dropped.
- ovf_clr_i  input  1  clears overflow_o (and counter, see Configuration).
- ovf_cnt_o  output  8  dropped-byte count; present only with the macro below.

## Operation

- Storage: DEPTH x 8 register array. Write and read pointers are $clog2(DEPTH)+1 bits, the MSB being a wrap bit. Pointers wrap modulo 2*DEPTH. Array index = pointer LSBs.
- empty: ptrs equal. full: LSBs equal, MSBs differ. count_o = wr_ptr - rd_ptr, computed modulo 2*DEPTH.
- Pop: pop = m_valid_o & m_ready_i. It advances rd_ptr by 1.
- Push: push = rx_done_i & (!full_o | pop). It writes rx_data_i at wr_ptr and advances wr_ptr by 1.
- Drop: drop = rx_done_i & full_o & !pop. The byte is discarded, pointers are unchanged, and overflow_o is set to 1.
- Simultaneous push and pop: both pointers advance and count_o is unchanged. When full with a simultaneous pop, the push is accepted, no drop occurs, and the FIFO stays full.
- Head output: m_valid_o = !empty_o. m_data_o = mem[rd_ptr] when non-empty, 8'h00 when empty. m_data_o is stable while m_valid_o=1 and pop=0.
- Overflow: ovf_clr_i=1 clears overflow_o. If drop and ovf_clr_i occur in the same cycle, set wins and overflow_o=1.
- rx_data_i is ignored when rx_done_i=0. Back-to-back rx_done_i pulses are legal; each is a separate byte.
- No state machine beyond the pointers and the sticky flag.

## Timing

- Reset (resetn=0 at a rising edge) forces:
  - wr_ptr=0, rd_ptr=0, overflow_o=0, ovf_cnt_o=0.
  - Resulting outputs: m_valid_o=0, m_data_o=8'h00, empty_o=1, full_o=0, almost_full_o=0, count_o=0.
- Array contents are not reset.
- Reset mid-operation discards all stored bytes at that edge. Inputs during reset are ignored.
- Write-to-read latency is 1 cycle. After a push at edge N, m_valid_o=1 and m_data_o=byte from edge N onward, so a consumer holding m_ready_i=1 pops it at edge N+1.
- A pop at edge N presents the next entry, or 8'h00 with m_valid_o=0, immediately after edge N.
- All status outputs are registered-state functions. They reflect pointer values after the edge; there is no combinational path from rx_done_i.
- m_valid_o does not depend on m_ready_i. m_ready_i may depend combinationally on m_valid_o.
- Sustained rate: one push and one pop per cycle.

## Configuration

- Macro: UART_RX_FIFO_OVF_CNT_EN.
- Defined:
  - ovf_cnt_o port exists: an 8-bit counter incremented on each drop, saturating at 8'hFF.
  - ovf_clr_i zeroes it. If drop and clear occur in the same cycle, the result is 1.
  - Reset value is 0.
- Undefined: ovf_cnt_o port and counter are absent. Only the sticky overflow_o exists. All other behaviour is identical.

## Test plan

- Reset, then idle: m_valid_o=0, m_data_o=8'h00, count_o=0, empty_o=1, overflow_o=0.
- Push 8'hA5 with m_ready_i=0: next cycle m_valid_o=1, m_data_o=8'hA5, count_o=1. Raise m_ready_i for one cycle: empty again, m_data_o=8'h00.
- Push 16 bytes 8'h00..8'h0F with DEPTH=16 and no pops:
  - almost_full_o rises when count_o reaches 12; full_o=1 at count_o=16.
  - A 17th push (8'hFF) is dropped: overflow_o=1, count_o=16, ovf_cnt_o=1 with the macro.
  - Draining yields 8'h00..8'h0F in order.
- Full FIFO with rx_done_i and pop in the same cycle: no drop, count_o stays 16, overflow_o stays 0. The new byte emerges last.
- Continuous push+pop for 40 cycles (pointer wrap), bytes incrementing from 8'h10: output sequence is identical, count_o is constant.
- With the macro defined:
  - Drop 300 bytes into a full FIFO: ovf_cnt_o saturates at 8'hFF.
  - Assert ovf_clr_i with a concurrent drop: overflow_o=1, ovf_cnt_o=1.
  - Assert resetn=0 mid-stream: all outputs return to their reset values.
